// File: rtl/cdc_fifo_stream_reader.sv
// Read-side adapter for the async CDC FIFO: pops FIFO words into a two-entry
// skid buffer and presents them downstream as a registered valid/ready stream.
module cdc_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  input  logic                  flush,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_level
);

  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [1:0]            r_occ;

  logic                  w_pop;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_headNext;
  logic [DATA_WIDTH-1:0] w_skidNext;
  logic [1:0]            w_occNext;

  // Pop decision uses only registered state and r_empty, never o_ready.
  assign w_pop   = r_run & ~r_empty & ~flush & (r_occ < 2'd2);
  assign w_xfer  = o_valid & o_ready;
  assign r_inc   = w_pop;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head;
  assign o_level = r_occ;

  always_comb begin
    w_headNext = r_head;
    w_skidNext = r_skid;
    w_occNext  = r_occ;
    if (flush) begin
      w_occNext = 2'd0;
    end else begin
      case ({w_pop, w_xfer})
        2'b10: begin
          if (r_occ == 2'd0) w_headNext = r_data;
          else               w_skidNext = r_data;
          w_occNext = r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) w_headNext = r_skid;
          w_occNext = r_occ - 2'd1;
        end
        // Simultaneous pop and transfer only happens at occupancy 1.
        2'b11: w_headNext = r_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_head <= '0;
      r_skid <= '0;
      r_occ  <= 2'd0;
    end else begin
      r_run  <= 1'b1;
      r_head <= w_headNext;
      r_skid <= w_skidNext;
      r_occ  <= w_occNext;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_stream_reader.sv
// Self-checking bench: a queue-based FIFO model feeds the reader, and a
// scoreboard of written words checks order, occupancy and the pop strobe.
`timescale 1ns/100ps
module tb_cdc_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       wClk = 1'b0;
  logic       rst_n = 1'b1;
  logic       r_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       r_inc;
  logic       flush = 1'b0;
  logic       o_valid;
  logic       o_ready = 1'b0;
  logic [7:0] o_data;
  logic [1:0] o_level;

  cdc_fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .r_empty (r_empty),
    .r_data  (r_data),
    .r_inc   (r_inc),
    .flush   (flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_level (o_level)
  );

  always #5 clk = ~clk;
  initial begin
    #0.3;
    forever #6.5 wClk = ~wClk;
  end

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] fifoQ[$];
  logic [7:0] pendingQ[$];
  logic [7:0] expQ[$];
  int         bufCnt = 0;
  bit         popArmed = 1'b0;
  bit         runModel = 1'b0;
  bit         randomOn = 1'b0;
  int         wordsWritten = 0;
  int         burstLeft = 0;
  int         delivered = 0;
  logic [7:0] wWord;

  typedef struct {
    bit         ready;
    bit         fl;
    bit         expValid;
    int         expLevel;
    logic [7:0] expData;
    bit         expInc;
  } vec_t;
  vec_t stallVec[7];

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void updateFifo();
    r_empty = (fifoQ.size() == 0);
    r_data  = r_empty ? 8'h00 : fifoQ[0];
  endfunction

  task automatic pushWord(input logic [7:0] w);
    fifoQ.push_back(w);
    expQ.push_back(w);
    updateFifo();
  endtask

  task automatic applyStimulus(input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    o_ready = rdy;
    flush   = fl;
  endtask

  // Words held inside the reader are always the oldest undelivered ones.
  task automatic dropBuffered();
    repeat (bufCnt) if (expQ.size() > 0) void'(expQ.pop_front());
    bufCnt = 0;
  endtask

  task automatic waitDrain(input int maxCycles, input string name);
    bit done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      #1;
      done = (bufCnt == 0) && (fifoQ.size() == 0) && (pendingQ.size() == 0);
    end
    checkOutput(name, int'(done), 1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) runModel <= 1'b0;
    else        runModel <= 1'b1;
  end

  // FIFO model: applies the pop seen before the edge, then lands pending writes.
  always @(posedge clk) begin
    #1;
    if (popArmed) begin
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      bufCnt++;
      popArmed = 1'b0;
    end
    while (pendingQ.size() > 0) fifoQ.push_back(pendingQ.pop_front());
    updateFifo();
  end

  // Bursty writer in an unrelated clock domain.
  always @(posedge wClk) begin
    if (randomOn && wordsWritten < 1000) begin
      if (burstLeft == 0 && $urandom_range(0, 5) == 0) burstLeft = $urandom_range(1, 10);
      if (burstLeft > 0) begin
        wWord = 8'(wordsWritten * 37 + 5);
        pendingQ.push_back(wWord);
        expQ.push_back(wWord);
        wordsWritten++;
        burstLeft--;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      popArmed = 1'b0;
    end else begin
      checkOutput("level", int'(o_level), bufCnt);
      checkOutput("valid", int'(o_valid), int'(bufCnt != 0));
      if (o_valid && expQ.size() > 0) checkOutput("data", int'(o_data), int'(expQ[0]));
      checkOutput("r_inc", int'(r_inc),
                  int'(runModel && !r_empty && !flush && bufCnt < 2));
      checkOutput("incWhileEmpty", int'(r_inc && r_empty), 0);
      if (o_valid && o_ready) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        if (bufCnt > 0) bufCnt--;
        delivered++;
      end
      if (flush) dropBuffered();
      popArmed = r_inc;
    end
  end

  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int startCnt;
    bit done;

    stallVec[0] = '{1'b0, 1'b0, 1'b1, 1, 8'hA0, 1'b1};
    stallVec[1] = '{1'b0, 1'b0, 1'b1, 2, 8'hA0, 1'b0};
    stallVec[2] = '{1'b0, 1'b0, 1'b1, 2, 8'hA0, 1'b0};
    stallVec[3] = '{1'b1, 1'b0, 1'b1, 2, 8'hA0, 1'b0};
    stallVec[4] = '{1'b1, 1'b0, 1'b1, 1, 8'hA1, 1'b1};
    stallVec[5] = '{1'b1, 1'b0, 1'b1, 1, 8'hA2, 1'b0};
    stallVec[6] = '{1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};

    // Reset values, then release with two words already waiting.
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("rstValid", int'(o_valid), 0);
    checkOutput("rstLevel", int'(o_level), 0);
    checkOutput("rstData", int'(o_data), 0);
    checkOutput("rstInc", int'(r_inc), 0);
    pushWord(8'h11);
    pushWord(8'h22);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("releaseInc", int'(r_inc), 0);
    @(negedge clk);
    checkOutput("firstPopInc", int'(r_inc), 1);
    checkOutput("preFirstValid", int'(o_valid), 0);
    @(negedge clk);
    checkOutput("firstValid", int'(o_valid), 1);
    checkOutput("firstData", int'(o_data), 8'h11);
    waitDrain(20, "drainAfterRelease");

    // Streaming: 16 words with o_ready held high.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) pushWord(8'(k));
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("streamValid%0d", k), int'(o_valid), 1);
      checkOutput($sformatf("streamData%0d", k), int'(o_data), k - 1);
      checkOutput($sformatf("streamLevel%0d", k), int'(o_level), 1);
      checkOutput($sformatf("streamInc%0d", k), int'(r_inc), int'(k < 16));
    end
    @(negedge clk);
    checkOutput("streamEndValid", int'(o_valid), 0);

    // Stall then release, table driven.
    applyStimulus(1'b0, 1'b0);
    pushWord(8'hA0);
    pushWord(8'hA1);
    pushWord(8'hA2);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stallVec[i].ready, stallVec[i].fl);
      @(negedge clk);
      checkOutput($sformatf("stallValid%0d", i), int'(o_valid), int'(stallVec[i].expValid));
      checkOutput($sformatf("stallLevel%0d", i), int'(o_level), stallVec[i].expLevel);
      checkOutput($sformatf("stallInc%0d", i), int'(r_inc), int'(stallVec[i].expInc));
      if (stallVec[i].expValid)
        checkOutput($sformatf("stallData%0d", i), int'(o_data), int'(stallVec[i].expData));
    end

    // Flush with a full buffer; the word left in the FIFO follows normally.
    applyStimulus(1'b0, 1'b0);
    pushWord(8'hB0);
    pushWord(8'hB1);
    pushWord(8'hB2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("preFlushLevel", int'(o_level), 2);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flushCycleInc", int'(r_inc), 0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postFlushValid", int'(o_valid), 0);
    checkOutput("postFlushLevel", int'(o_level), 0);
    checkOutput("postFlushInc", int'(r_inc), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("afterFlushValid", int'(o_valid), 1);
    checkOutput("afterFlushData", int'(o_data), 8'hB2);
    waitDrain(20, "drainAfterFlush");

    // Asynchronous reset mid-stream with a full buffer.
    applyStimulus(1'b0, 1'b0);
    pushWord(8'hC0);
    pushWord(8'hC1);
    pushWord(8'hC2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("preResetLevel", int'(o_level), 2);
    #2;
    rst_n = 1'b0;
    dropBuffered();
    popArmed = 1'b0;
    #1;
    checkOutput("midRstValid", int'(o_valid), 0);
    checkOutput("midRstLevel", int'(o_level), 0);
    checkOutput("midRstInc", int'(r_inc), 0);
    checkOutput("midRstData", int'(o_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    startCnt = delivered;
    waitDrain(20, "drainAfterReset");
    checkOutput("resumeCount", delivered - startCnt, 1);

    // Random back-pressure against bursty cross-domain writes.
    startCnt = delivered;
    randomOn = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 12000 && !done; c++) begin
      @(posedge clk);
      #1;
      o_ready = 1'($urandom_range(0, 1));
      flush   = 1'b0;
      @(negedge clk);
      #1;
      done = (wordsWritten == 1000) && (expQ.size() == 0) && (pendingQ.size() == 0);
    end
    randomOn = 1'b0;
    checkOutput("randomDone", int'(done), 1);
    checkOutput("randomCount", delivered - startCnt, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
